// File: rtl/edge_sync_pkg.sv
// -----------------------------------------------------------------------------
// edge_sync_pkg
// Shared types for the multi-channel edge synchroniser.
//   edge_mode_t  : per-channel edge selection (off / rise / fall / both)
//   filt_state_t : per-channel stability-filter state
// Helpers decode whether a mode enables rising or falling events.
// -----------------------------------------------------------------------------
package edge_sync_pkg;

  typedef enum logic [1:0] {
    EDGE_OFF  = 2'b00,
    EDGE_RISE = 2'b01,
    EDGE_FALL = 2'b10,
    EDGE_BOTH = 2'b11
  } edge_mode_t;

  typedef enum logic [1:0] {
    LOW       = 2'b00,
    QUAL_HIGH = 2'b01,
    HIGH      = 2'b10,
    QUAL_LOW  = 2'b11
  } filt_state_t;

  function automatic logic rise_enabled(input edge_mode_t m);
    return (m == EDGE_RISE) || (m == EDGE_BOTH);
  endfunction

  function automatic logic fall_enabled(input edge_mode_t m);
    return (m == EDGE_FALL) || (m == EDGE_BOTH);
  endfunction

endpackage

// File: rtl/edge_sync_channel.sv
// -----------------------------------------------------------------------------
// edge_sync_channel
// One channel of the edge synchroniser: synchroniser chain, stability filter
// (FSM + counter), edge event generation and sticky pending/overflow flags.
// Ports:
//   clk        : block clock
//   clr        : asynchronous active-high reset
//   async_i    : raw asynchronous input
//   mode_i     : edge mode (00 off, 01 rise, 10 fall, 11 both)
//   ack_i      : pending clear, sampled on clk
//   level_o    : filtered, synchronised level
//   pulse_o    : one-cycle event strobe
//   pending_o  : sticky event flag
//   overflow_o : sticky missed-event flag
// -----------------------------------------------------------------------------
module edge_sync_channel
  import edge_sync_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER      = 1
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       async_i,
  input  logic [1:0] mode_i,
  input  logic       ack_i,
  output logic       level_o,
  output logic       pulse_o,
  output logic       pending_o,
  output logic       overflow_o
);

  localparam int CNT_W = $clog2(FILTER + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  filt_state_t            state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   pulse_q, pulse_d;
  logic                   pending_q, pending_d;
  logic                   overflow_q, overflow_d;

  logic       synced;
  logic       acc_rise, acc_fall;
  edge_mode_t mode;

  assign synced = sync_q[SYNC_STAGES-1];
  assign mode   = edge_mode_t'(mode_i);

  // Synchroniser chain: bit 0 captures the raw input.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
    end
  end

  // Filter FSM. The filtered level is implied by the state: HIGH and
  // QUAL_LOW mean the accepted level is 1. The counter holds how many
  // consecutive cycles the synced level has already disagreed; the cycle
  // on which it reaches FILTER-1 and still disagrees is the acceptance.
  // With FILTER=1 CNT_LAST is 0, so LOW/HIGH accept directly and the
  // QUAL states are never entered.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_rise = 1'b0;
    acc_fall = 1'b0;
    case (state_q)
      LOW, QUAL_HIGH: begin
        if (!synced) begin
          state_d = LOW;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d  = HIGH;
          cnt_d    = '0;
          acc_rise = 1'b1;
        end else begin
          state_d = QUAL_HIGH;
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      HIGH, QUAL_LOW: begin
        if (synced) begin
          state_d = HIGH;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d  = LOW;
          cnt_d    = '0;
          acc_fall = 1'b1;
        end else begin
          state_d = QUAL_LOW;
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = LOW;
        cnt_d   = '0;
      end
    endcase
  end

  // Event and sticky flags. A coincident event and ack leaves pending set
  // (the new event replaces the acknowledged one) and overflow untouched.
  always_comb begin
    pulse_d    = (acc_rise && rise_enabled(mode)) || (acc_fall && fall_enabled(mode));
    pending_d  = pending_q;
    overflow_d = overflow_q;
    if (pulse_d) begin
      pending_d = 1'b1;
      if (pending_q && !ack_i) begin
        overflow_d = 1'b1;
      end
    end else if (ack_i) begin
      pending_d  = 1'b0;
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q    <= LOW;
      cnt_q      <= '0;
      pulse_q    <= 1'b0;
      pending_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pulse_q    <= pulse_d;
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
    end
  end

  assign level_o    = (state_q == HIGH) || (state_q == QUAL_LOW);
  assign pulse_o    = pulse_q;
  assign pending_o  = pending_q;
  assign overflow_o = overflow_q;

endmodule

// File: rtl/multi_edge_sync.sv
// -----------------------------------------------------------------------------
// multi_edge_sync
// Multi-channel edge synchroniser and event latch. Each of CH asynchronous
// inputs is synchronised, stability-filtered and edge-detected independently.
// Ports:
//   clk         : block clock
//   clr         : asynchronous active-high reset
//   async_in    : raw asynchronous inputs [CH]
//   mode        : per-channel edge mode, bits [2i+1:2i] for channel i
//   ack         : per-channel pending clear [CH]
//   level_out   : filtered synchronised levels [CH]
//   pulse_out   : one-cycle event strobes [CH]
//   pending     : sticky event flags [CH]
//   overflow    : sticky missed-event flags [CH]
//   any_pending : OR of pending
// -----------------------------------------------------------------------------
module multi_edge_sync #(
  parameter int CH          = 4,
  parameter int SYNC_STAGES = 2,
  parameter int FILTER      = 1
) (
  input  logic            clk,
  input  logic            clr,
  input  logic [CH-1:0]   async_in,
  input  logic [2*CH-1:0] mode,
  input  logic [CH-1:0]   ack,
  output logic [CH-1:0]   level_out,
  output logic [CH-1:0]   pulse_out,
  output logic [CH-1:0]   pending,
  output logic [CH-1:0]   overflow,
  output logic            any_pending
);

  generate
    for (genvar gi = 0; gi < CH; gi++) begin : g_ch
      edge_sync_channel #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILTER      (FILTER)
      ) u_ch (
        .clk        (clk),
        .clr        (clr),
        .async_i    (async_in[gi]),
        .mode_i     (mode[2*gi+1:2*gi]),
        .ack_i      (ack[gi]),
        .level_o    (level_out[gi]),
        .pulse_o    (pulse_out[gi]),
        .pending_o  (pending[gi]),
        .overflow_o (overflow[gi])
      );
    end
  endgenerate

  assign any_pending = |pending;

endmodule

// File: doc/multi_edge_sync.md
# multi_edge_sync

Multi-channel edge synchroniser and event latch: brings `CH` asynchronous inputs into the `clk` domain through a configurable-depth synchroniser chain, applies a per-channel stability filter, and detects edges with a per-channel mode (rise/fall/both/off). Each edge produces a one-cycle pulse and sets a sticky pending flag, cleared by an acknowledge handshake. If a new event arrives while the flag is still pending, a sticky overflow bit is set. The block sits between off-chip/slow-domain sources (keys, switches, foreign-clock strobes) and `clk`-domain FSMs. It replaces the single-channel async-set pulse catcher.

## Interface
- `CH`, 4: number of independent channels (≥1)
- `SYNC_STAGES`, 2: synchroniser flops per channel (≥2)
- `FILTER`, 1: consecutive `clk` cycles a synced level must differ from the filtered level before it is accepted (≥1)
- `CNT_W`, $clog2(FILTER+1): width of the filter counter (derived localparam, not overridden)

- `clk` in 1: block clock
- `clr` in 1: reset, asynchronous, active-high
- `async_in` in CH: raw asynchronous inputs
- `mode` in 2*CH: per-channel edge mode; bits [2i+1:2i] for channel i; 00 off, 01 rise, 10 fall, 11 both
- `ack` in CH: per-channel pending clear, sampled on `clk`
- `level_out` out CH: filtered, synchronised level
- `pulse_out` out CH: one-cycle event strobe
- `pending` out CH: sticky event flag
- `overflow` out CH: sticky missed-event flag
- `any_pending` out 1: OR of `pending`

## Operation
- Channel i: synchroniser chain s[0..SYNC_STAGES-1] → synced level `s`; filtered level `f` (= `level_out[i]`); filter counter `cnt`.
- Filter: if `s == f`, `cnt` ← 0. Otherwise `cnt` ← `cnt`+1, and when `cnt == FILTER-1`, `f` ← `s` and `cnt` ← 0. A glitch shorter than `FILTER` synced cycles is discarded. `f` tracks the level regardless of `mode`.
- Per-channel FSM: LOW, QUAL_HIGH, HIGH, QUAL_LOW.
  - LOW→QUAL_HIGH when `s`=1 and FILTER>1.
  - QUAL_HIGH→LOW when `s`=0.
  - QUAL_HIGH→HIGH on acceptance.
  - Falling direction is symmetric.
  - When FILTER=1, acceptance is direct: LOW→HIGH or HIGH→LOW.
- Event: an accepted 0→1 transition with mode bit0=1, or an accepted 1→0 transition with mode bit1=1. The event is registered on the same edge that updates `f`.
- On an event, `pulse_out[i]`=1 for exactly one cycle.
- Pending flag, next-value priority:
  1. event → `pending`=1
  2. `ack` → `pending`=0
  3. otherwise hold.
- Event and `ack` in the same cycle: `pending` stays 1 and `overflow` is unchanged. The acknowledged event is consumed and the new one latched.
- Event while `pending`=1 and `ack`=0: `overflow` ← 1. `ack` without a concurrent overflow condition clears `overflow`.
- A `mode` change takes effect for acceptances on the next `clk` edge. An in-progress qualification is unaffected. Mode 00 suppresses pulses and pending, but not `level_out`.

## Timing
- Reset values:
  - all sync flops, `f`, `cnt`, `pulse_out`, `pending`, `overflow` = 0
  - `any_pending` = 0
  - FSM = LOW
- A channel held high through reset release produces a rise event after normal latency.
- Latency: an async edge captured by s[0] at edge k gives `level_out`/`pulse_out`/`pending` high after edge k+SYNC_STAGES-1+FILTER. With defaults, that is 2 cycles after capture.
- `pulse_out` width: exactly 1 cycle. Minimum spacing between events on one channel: FILTER cycles.
- `ack` to `pending` low: 1 cycle. `any_pending` is combinational from `pending` registers.
- `clr` asserted mid-qualification or with pending set: everything returns to reset values immediately, asynchronously. No event is emitted for the interrupted transition.
- Channels are fully independent. Simultaneous events on all CH channels are all latched.

## Structure
- Package `edge_sync_pkg`:
  - `edge_mode_t` enum (EDGE_OFF, EDGE_RISE, EDGE_FALL, EDGE_BOTH)
  - `filt_state_t` enum (LOW, QUAL_HIGH, HIGH, QUAL_LOW)
- Sub-module `edge_sync_channel` holds one channel: chain, filter FSM/counter, and pending/overflow logic. It is instantiated CH times by a generate loop in `multi_edge_sync`, which also forms `any_pending`.

## Test plan
- Defaults, ch0 mode=01, `async_in[0]` 0→1 → `pulse_out[0]`=1 for 1 cycle and `pending[0]`=1, both 2 cycles after capture; `ack[0]` pulse → `pending[0]`=0 next cycle.
- FILTER=4, ch1 mode=11, 2-cycle high glitch → no pulse and `level_out[1]` stays 0. 6-cycle high pulse → rise event at capture+5, then fall event after the low level persists 4 cycles.
- Ch2 mode=10: rise → no pulse. Fall → pulse. Mode=00 with toggles → `level_out` follows, with no pulse and no `pending`.
- Two ch3 rise events without `ack` → `overflow[3]`=1. An event coincident with `ack` → `pending[3]` stays 1 and `overflow[3]` stays 0. A later lone `ack` clears both.
- All 4 channels toggle in the same cycle, mode=11 → 4 simultaneous pulses; `any_pending`=1 until the last `ack`.
- `clr` asserted mid-qualification (FILTER=4, cnt=2) and with `pending`=1 → all outputs 0 immediately. Input held high across `clr` release → rise event at normal latency.
